// File: rtl/axi4s_ram.sv
// AXI4 slave on-chip RAM: word-organised synchronous memory behind independent
// write (AW/W/B) and read (AR/R) state machines, serving single, INCR and FIXED bursts.
module axi4s_ram #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_AW     = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam int NB    = AXI_DATA_W / 8;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // ready depends only on FSM state, never combinationally on the matching valid.
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [AXI_DATA_W-1:0] mem_q [DEPTH];

    w_state_e          w_state_q, w_state_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d;
    logic              mem_we;

    r_state_e          r_state_q, r_state_d;
    logic [MEM_AW-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_en;
    logic [MEM_AW-1:0] rd_idx;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_arsize,
                         s_axi_awaddr[AXI_ADDR_W-1:MEM_AW+2], s_axi_awaddr[1:0],
                         s_axi_araddr[AXI_ADDR_W-1:MEM_AW+2], s_axi_araddr[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    waddr_d   = s_axi_awaddr[MEM_AW+1:2];
                    wlen_d    = s_axi_awlen;
                    wburst_d  = s_axi_awburst;
                    wcnt_d    = 8'd0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we = 1'b1;
                    // wlast must coincide exactly with the beat the counter calls final
                    if (s_axi_wlast != (wcnt_q == wlen_q)) werr_d = 1'b1;
                    if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                        if (wburst_q != BURST_FIXED) waddr_d = waddr_q + MEM_AW'(1);
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rburst_d  = rburst_q;
        rd_en     = 1'b0;
        rd_idx    = raddr_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    rd_idx    = s_axi_araddr[MEM_AW+1:2];
                    rd_en     = 1'b1;
                    raddr_d   = rd_idx;
                    rlen_d    = s_axi_arlen;
                    rburst_d  = s_axi_arburst;
                    rcnt_d    = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        // Prefetch the next beat in the accepting cycle so bursts stream
                        rd_idx  = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + MEM_AW'(1);
                        rd_en   = 1'b1;
                        raddr_d = rd_idx;
                        rcnt_d  = rcnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        rdata_d = rd_en ? mem_q[rd_idx] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rburst_q  <= rburst_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is not reset; a write arriving on a reset edge is dropped
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) mem_q[waddr_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_awready = (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = (w_state_q == W_RESP && werr_q) ? 2'b10 : 2'b00;
    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rlast   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi4s_ram.sv
// Self-checking bench for axi4s_ram: table of single-beat write/read vectors,
// then hand-written sequences for bursts, stalls, wlast errors, wrap, overlap and reset.
module tb_axi4s_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi4s_ram dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int n_total = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] wbeat [16];
    logic [31:0] rbeat [16];
    logic        rlast_seen [16];
    int          bubbles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drives one AW burst with beats from wbeat[]; lat = cycles from AW to B handshake
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input logic [15:0] wlast_mask,
                             output logic [1:0] resp, output int lat);
        int guard;
        int t_aw;
        resp = 2'b11;
        lat = -1;
        @(negedge clk);
        awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin chk("aw_timeout", 32'd0, 32'd1); awvalid = 1'b0; return; end
        @(negedge clk);
        t_aw = cyc;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbeat[i]; wstrb = strb; wlast = wlast_mask[i]; wvalid = 1'b1;
            guard = 0;
            while (!wready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) begin chk("w_timeout", 32'd0, 32'd1); wvalid = 1'b0; return; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        guard = 0;
        while (!bvalid && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin chk("b_timeout", 32'd0, 32'd1); bready = 1'b0; return; end
        resp = bresp;
        @(negedge clk);
        lat = cyc - t_aw;
        bready = 1'b0;
    endtask

    // Reads one AR burst into rbeat[]/rlast_seen[]; toggle=1 stalls every other cycle
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input bit toggle, output logic first_ok);
        int guard;
        int n;
        int beat;
        bit stalled;
        logic [31:0] hold_d;
        logic hold_l;
        first_ok = 1'b0;
        @(negedge clk);
        araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = 1'b0;
        guard = 0;
        while (!arready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin chk("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        first_ok = rvalid;
        n = 0; beat = 0; bubbles = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
        while (beat <= int'(len) && n < 200) begin
            if (n > 0) @(negedge clk);
            n++;
            rready = toggle ? (n % 2 == 0) : 1'b1;
            if (!rvalid) begin
                bubbles++;
            end else begin
                if (stalled) begin
                    chk("r_hold_data", rdata, hold_d);
                    chk("r_hold_last", 32'(rlast), 32'(hold_l));
                end
                if (rready) begin
                    rbeat[beat] = rdata; rlast_seen[beat] = rlast; beat++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; hold_d = rdata; hold_l = rlast;
                end
            end
        end
        if (beat <= int'(len)) chk("r_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rready = 1'b0;
        chk("r_valid_drop", 32'(rvalid), 32'd0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        logic [1:0] resp;
        int lat;
        logic first_ok;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0024, 32'h0123_4567, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0024, 32'h89AB_CDEF, 4'hA, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h8923_CD67};
        vecs[8]  = '{1'b1, 32'h0000_4010, 32'h5A5A_5A5A, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h5A5A_5A5A};
        vecs[10] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h5A5A_5A5A};

        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        chk("w_before_aw_wready", 32'(wready), 32'd0);
        wvalid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                wbeat[0] = vecs[i].data;
                axi_write(vecs[i].addr, 8'd0, 2'b01, vecs[i].strb, 16'h0001, resp, lat);
                chk($sformatf("vec%0d_bresp", i), 32'(resp), vecs[i].exp);
                chk($sformatf("vec%0d_aw_to_b", i), 32'(lat), 32'd2);
            end else begin
                axi_read(vecs[i].addr, 8'd0, 2'b01, 1'b0, first_ok);
                chk($sformatf("vec%0d_rdata", i), rbeat[0], vecs[i].exp);
                chk($sformatf("vec%0d_rlast", i), 32'(rlast_seen[0]), 32'd1);
                chk($sformatf("vec%0d_rvalid_next", i), 32'(first_ok), 32'd1);
            end
        end

        // INCR burst, streamed and then stalled
        for (int i = 0; i < 4; i++) wbeat[i] = 32'(i + 1);
        axi_write(32'h100, 8'd3, 2'b01, 4'hF, 16'h0008, resp, lat);
        chk("incr_w_bresp", 32'(resp), 32'd0);
        axi_read(32'h100, 8'd3, 2'b01, 1'b0, first_ok);
        chk("incr_r_bubbles", 32'(bubbles), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_r_beat%0d", i), rbeat[i], 32'(i + 1));
            chk($sformatf("incr_r_last%0d", i), 32'(rlast_seen[i]), (i == 3) ? 32'd1 : 32'd0);
        end
        axi_read(32'h100, 8'd3, 2'b01, 1'b1, first_ok);
        for (int i = 0; i < 4; i++) chk($sformatf("incr_stall_beat%0d", i), rbeat[i], 32'(i + 1));
        chk("incr_stall_last", 32'(rlast_seen[3]), 32'd1);

        // FIXED burst overwrites one word; neighbour untouched
        wbeat[0] = 32'h4444_4444;
        axi_write(32'h44, 8'd0, 2'b01, 4'hF, 16'h0001, resp, lat);
        wbeat[0] = 32'd5; wbeat[1] = 32'd6; wbeat[2] = 32'd7;
        axi_write(32'h40, 8'd2, 2'b00, 4'hF, 16'h0004, resp, lat);
        chk("fixed_w_bresp", 32'(resp), 32'd0);
        axi_read(32'h40, 8'd0, 2'b01, 1'b0, first_ok);
        chk("fixed_r_40", rbeat[0], 32'd7);
        axi_read(32'h44, 8'd0, 2'b01, 1'b0, first_ok);
        chk("fixed_r_44", rbeat[0], 32'h4444_4444);
        axi_read(32'h40, 8'd1, 2'b00, 1'b0, first_ok);
        chk("fixed_rburst_b0", rbeat[0], 32'd7);
        chk("fixed_rburst_b1", rbeat[1], 32'd7);

        // wlast protocol errors
        wbeat[0] = 32'h1; wbeat[1] = 32'h2;
        axi_write(32'h200, 8'd1, 2'b01, 4'hF, 16'h0003, resp, lat);
        chk("wlast_early_bresp", 32'(resp), 32'd2);
        axi_write(32'h200, 8'd0, 2'b01, 4'hF, 16'h0000, resp, lat);
        chk("wlast_missing_bresp", 32'(resp), 32'd2);
        axi_write(32'h200, 8'd1, 2'b01, 4'hF, 16'h0002, resp, lat);
        chk("wlast_ok_bresp", 32'(resp), 32'd0);

        // INCR burst wrapping past the top word of memory
        wbeat[0] = 32'hA0A0_A0A0; wbeat[1] = 32'hB0B0_B0B0;
        axi_write(32'h3FFC, 8'd1, 2'b01, 4'hF, 16'h0002, resp, lat);
        axi_read(32'h0, 8'd0, 2'b01, 1'b0, first_ok);
        chk("wrap_r_word0", rbeat[0], 32'hB0B0_B0B0);
        axi_read(32'h3FFC, 8'd1, 2'b01, 1'b0, first_ok);
        chk("wrap_rburst_b0", rbeat[0], 32'hA0A0_A0A0);
        chk("wrap_rburst_b1", rbeat[1], 32'hB0B0_B0B0);

        // Write and read of the same word in the same cycle: read sees old data
        @(negedge clk);
        awaddr = 32'h10; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 32'h7777_7777; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        chk("overlap_rvalid", 32'(rvalid), 32'd1);
        chk("overlap_rdata_old", rdata, 32'h5A5A_5A5A);
        chk("overlap_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk("overlap_bvalid_drop", 32'(bvalid), 32'd0);
        axi_read(32'h10, 8'd0, 2'b01, 1'b0, first_ok);
        chk("overlap_r_new", rbeat[0], 32'h7777_7777);

        // Reset during beat 2 of a 4-beat read
        @(negedge clk);
        araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_beat2", rdata, 32'd3);
        rst_n = 1'b0; rready = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid", 32'(rvalid), 32'd0);
        chk("rstmid_rlast", 32'(rlast), 32'd0);
        chk("rstmid_arready", 32'(arready), 32'd1);
        chk("rstmid_awready", 32'(awready), 32'd1);
        rst_n = 1'b1;
        axi_read(32'h100, 8'd0, 2'b01, 1'b0, first_ok);
        chk("rstmid_reread", rbeat[0], 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/axi4s_ram.md
Name: axi4s_ram

Overview:
- AXI4 slave on-chip RAM that sits directly downstream of the core's native-to-AXI4 master bridge.
- Terminates all five AXI4 channels and serves single-beat and INCR/FIXED burst transfers from a word-organised synchronous memory.
- The read and write paths are independent state machines, so a read and a write can be in flight at the same time.
- Used as boot/data RAM in the single-core system and as the bench target for the bridge.

Parameters:
- AXI_ADDR_W, 32, AXI address width
- AXI_DATA_W, 32, AXI data width; only 32 is supported
- MEM_AW, 12, word-address bits; depth = 2^MEM_AW words (16 KiB default)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_axi_awaddr  in  AXI_ADDR_W  write address
- s_axi_awlen  in  8  write burst length minus 1
- s_axi_awsize  in  3  ignored (word transfers only)
- s_axi_awburst  in  2  write burst type
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  AXI_DATA_W  write data
- s_axi_wstrb  in  AXI_DATA_W/8  byte strobes
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_araddr  in  AXI_ADDR_W  read address
- s_axi_arlen  in  8  read burst length minus 1
- s_axi_arsize  in  3  ignored
- s_axi_arburst  in  2  read burst type
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rdata  out  AXI_DATA_W  read data
- s_axi_rresp  out  2  read response; always 2'b00
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready

Lock, cache, prot and qos inputs are not present; the integrator leaves them unconnected.

Behaviour:

General rules
- One clock (clk); reset is synchronous and active-low (rst_n).
- Word index = addr[MEM_AW+1:2]; higher address bits and addr[1:0] are ignored.
- Memory contents are not reset.
- After reset: awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp = 0; rdata = 0.
- Burst types:
  - 2'b00 FIXED: the address stays constant for every beat.
  - 2'b01 INCR and 2'b10 WRAP: the address is incremented by one word per beat; WRAP is handled as INCR.
  - Word index arithmetic wraps modulo 2^MEM_AW.

Write FSM (W_IDLE, W_DATA, W_RESP)
- W_IDLE: awready=1. On aw_hs, latch address, len and burst; clear the beat counter and error flag; go to W_DATA.
- W_DATA: wready=1. On each w_hs, write each byte lane whose wstrb bit is set; bytes with wstrb=0 are unchanged.
- Error flag: set if wlast=1 on a beat other than the final one (beat counter != len), or if wlast=0 on the final beat.
- On the final beat, go to W_RESP. Otherwise advance the address and counter.
- W_RESP: bvalid=1; bresp = 2'b10 if the error flag is set, else 2'b00. Hold until b_hs, then return to W_IDLE.
- W data presented before the AW handshake is not accepted (wready=0 outside W_DATA).
- Best-case single-beat write: AW, then W on the next cycle, then B one cycle after W; the B handshake can complete 2 cycles after aw_hs.

Read FSM (R_IDLE, R_DATA)
- R_IDLE: arready=1. On ar_hs, latch len and burst, start the synchronous memory read of the araddr word, and go to R_DATA.
- R_DATA: rvalid=1 starting the cycle after ar_hs; rdata is registered. rlast=1 when the beat counter == len.
- On r_hs for a non-final beat: fetch the next-address word into rdata in the same cycle. rvalid stays 1, so a burst streams at one beat per cycle.
- On r_hs for the final beat: go to R_IDLE; rvalid and rlast drop the next cycle.
- With rready=0, rdata, rlast and rvalid hold stable.

Concurrency and reset
- Read and write may run concurrently. If a write and a read to the same word occur in the same cycle, the read returns the old data.
- Reset mid-operation: both FSMs return to idle and all valid/ready outputs take their reset values. An in-flight burst is abandoned; beats already written remain in memory.

Test Plan:
1. Single write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, wlast=1, bready=1 -> bvalid with bresp=00 two cycles after aw_hs. Then read araddr=0x10 -> rdata=0xDEADBEEF, rlast=1, rvalid the cycle after ar_hs.
2. Partial strobe: write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb=0x5 -> a read of 0x20 returns 0x11BB33DD.
3. INCR burst: write awlen=3 at 0x100 with data 1,2,3,4 (wlast on the 4th beat), then read arlen=3 with rready=1 every cycle -> 4 consecutive beats 1,2,3,4, rlast only on beat 4, no bubbles. Repeat the read with rready toggling -> data held stable while stalled.
4. FIXED burst: write awlen=2, awburst=00 at 0x40 with data 5,6,7 -> a read of 0x40 returns 7; 0x44 is unchanged.
5. wlast error: awlen=1 with wlast=1 on beat 0 -> bresp=2'b10. Then awlen=0 with wlast=0 -> bresp=2'b10.
6. Reset mid-burst: assert rst_n=0 during beat 2 of a 4-beat read -> next cycle rvalid=0, arready=1, awready=1. A new single read of 0x100 returns 1.
